// File: rtl/rv_mask_serializer.sv
// rv_mask_serializer: takes an N-bit thread mask over a valid/ready handshake
// and emits the index of every set bit, lowest first, one beat per output
// handshake, together with the mask's ones-count and the beat position.
// Optional macro RV_MASK_SER_BYPASS_EN: accept the next mask on the final
// beat of the current one so batches run back to back (adds a combinational
// out_ready_i -> in_ready_o path).
module rv_mask_serializer #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1,
    parameter int M    = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [N-1:0]    in_mask_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [IDXW-1:0] out_idx_o,
    output logic            out_last_o,
    output logic [M-1:0]    out_cnt_o,
    output logic [M-1:0]    out_pos_o
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t       state, state_nx;
    logic [N-1:0] pending, pending_nx;
    logic [M-1:0] cnt, cnt_nx;
    logic [M-1:0] pos, pos_nx;
    logic [N-1:0] low_bit;
    logic         accept;
    logic         beat_fire;

    // Index of the lowest set bit; 0 for an empty vector.
    function automatic logic [IDXW-1:0] lowest_idx(input logic [N-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    // Number of set bits; M bits always holds N.
    function automatic logic [M-1:0] ones_count(input logic [N-1:0] v);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r = r + M'(v[i]);
        end
        return r;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Output side is a pure function of registered state.
    assign out_valid_o = (state == EMIT);
    assign out_idx_o   = lowest_idx(pending);
    assign out_last_o  = is_single(pending);
    assign out_cnt_o   = cnt;
    assign out_pos_o   = pos;

`ifdef RV_MASK_SER_BYPASS_EN
    assign in_ready_o  = (state == IDLE) || (out_valid_o && out_ready_i && out_last_o);
`else
    assign in_ready_o  = (state == IDLE);
`endif

    // Isolates the lowest pending bit so it can be cleared after its beat.
    assign low_bit   = pending & (~pending + N'(1));
    assign beat_fire = out_valid_o && out_ready_i;
    assign accept    = in_valid_i && in_ready_o;

    // Next-state and next-datapath: retire a beat, then let a new mask override.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        cnt_nx     = cnt;
        pos_nx     = pos;
        if (beat_fire) begin
            if (out_last_o) begin
                state_nx   = IDLE;
                pending_nx = '0;
            end else begin
                pending_nx = pending & ~low_bit;
                pos_nx     = pos + M'(1);
            end
        end
        // A zero mask is swallowed: nothing is loaded and the state is untouched.
        if (accept && (in_mask_i != '0)) begin
            state_nx   = EMIT;
            pending_nx = in_mask_i;
            cnt_nx     = ones_count(in_mask_i);
            pos_nx     = '0;
        end
    end

    // State register; reset aborts any batch in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pending mask, count and position registers; reset to 0 so idle outputs are never X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            cnt     <= '0;
            pos     <= '0;
        end else begin
            pending <= pending_nx;
            cnt     <= cnt_nx;
            pos     <= pos_nx;
        end
    end

endmodule

// File: tb/tb_rv_mask_serializer.sv
// Testbench for rv_mask_serializer: N=8 table vectors, hand sequences and
// random masks against a bit-list reference model; N=5 and N=1 exhaustive.
module tb_rv_mask_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // N = 8 instance
    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] in_mask;
    logic [2:0] out_idx;
    logic [3:0] out_cnt, out_pos;

    // N = 5 instance
    logic       v5, r5, ov5, or5, ol5;
    logic [4:0] m5;
    logic [2:0] idx5, cnt5, pos5;

    // N = 1 instance
    logic       v1, r1, ov1, or1, ol1;
    logic [0:0] m1, idx1, cnt1, pos1;

    rv_mask_serializer #(.N(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mask_i(in_mask),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_idx_o(out_idx),
        .out_last_o(out_last), .out_cnt_o(out_cnt), .out_pos_o(out_pos)
    );

    rv_mask_serializer #(.N(5)) dut5 (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(v5), .in_ready_o(r5), .in_mask_i(m5),
        .out_valid_o(ov5), .out_ready_i(or5), .out_idx_o(idx5),
        .out_last_o(ol5), .out_cnt_o(cnt5), .out_pos_o(pos5)
    );

    rv_mask_serializer #(.N(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(v1), .in_ready_o(r1), .in_mask_i(m1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_idx_o(idx1),
        .out_last_o(ol1), .out_cnt_o(cnt1), .out_pos_o(pos1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one mask, drain it under the chosen ready pattern and compare every
    // beat with a list of set-bit positions. rmode: 0 always ready, 1 toggle, 2 random.
    task automatic run_mask(input logic [7:0] m, input int rmode,
                            output int nbeats, output int first, output int lastidx);
        int  q[$];
        int  pos;
        int  cyc;
        bit  rdy;
        logic [2:0] sidx;
        logic       svld;
        for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);
        nbeats = 0; first = 15; lastidx = 15;
        @(negedge clk);
        chk("pre_in_ready", in_ready, 1);
        in_valid = 1'b1; in_mask = m; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        pos = 0; cyc = 0;
        while (pos < q.size() && cyc < 100) begin
            @(negedge clk);
            cyc++;
            chk("beat_valid", out_valid, 1);
            chk("beat_idx", out_idx, q[pos]);
            chk("beat_cnt", out_cnt, q.size());
            chk("beat_pos", out_pos, pos);
            chk("beat_last", out_last, (pos == q.size() - 1));
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            sidx = out_idx; svld = out_valid;
            @(posedge clk); #1;
            if (rdy) begin
                if (svld) begin
                    if (nbeats == 0) first = sidx;
                    lastidx = sidx;
                    nbeats++;
                end
                pos++;
            end
        end
        chk("drain_in_budget", (cyc < 100), 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [7:0] mask;
        int         rmode;
        int         exp_beats;
        int         exp_first;
        int         exp_last;
    } vec_t;

    vec_t tbl[6];
    int   nb, fi, la;
    int   smp[4];
    int   exp_b2b[4];
    int   mq[$];
    int   got, lasts;

    initial begin
        tbl[0] = '{8'hA6, 0, 4, 1, 7};
        tbl[1] = '{8'hFF, 1, 8, 0, 7};
        tbl[2] = '{8'h00, 0, 0, 15, 15};
        tbl[3] = '{8'h01, 0, 1, 0, 0};
        tbl[4] = '{8'h80, 2, 1, 7, 7};
        tbl[5] = '{8'h3C, 1, 4, 2, 5};

        reset_n = 1'b0;
        in_valid = 1'b0; in_mask = '0; out_ready = 1'b1;
        v5 = 1'b0; m5 = '0; or5 = 1'b1;
        v1 = 1'b0; m1 = '0; or1 = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_pos", out_pos, 0);
        chk("rst_n5_ready", r5, 1);
        chk("rst_n1_ready", r1, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Table vectors
        for (int t = 0; t < 6; t++) begin
            run_mask(tbl[t].mask, tbl[t].rmode, nb, fi, la);
            chk("tbl_beats", nb, tbl[t].exp_beats);
            chk("tbl_first_idx", fi, tbl[t].exp_first);
            chk("tbl_last_idx", la, tbl[t].exp_last);
        end

        // Back-to-back 8'h81 then 8'h02 with in_valid held
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_mask = 8'h81;
        @(posedge clk); #1 in_mask = 8'h02;
        for (int c = 0; c < 4; c++) begin
            bit acc;
            @(negedge clk);
            smp[c] = out_valid ? int'(out_idx) : 8;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
`ifdef RV_MASK_SER_BYPASS_EN
        exp_b2b = '{0, 7, 1, 8};
`else
        exp_b2b = '{0, 7, 8, 1};
`endif
        for (int c = 0; c < 4; c++) chk("b2b_beat", smp[c], exp_b2b[c]);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_idle_ready", in_ready, 1);

        // Reset after the second beat of 8'hF0
        @(negedge clk);
        in_valid = 1'b1; in_mask = 8'hF0; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("rstmid_beat0", out_idx, 4);
        @(negedge clk); chk("rstmid_beat1", out_idx, 5);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_idx", out_idx, 0);
        chk("rstmid_last", out_last, 0);
        chk("rstmid_cnt", out_cnt, 0);
        chk("rstmid_pos", out_pos, 0);
        chk("rstmid_ready", in_ready, 1);
        @(negedge clk); reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid_no_beat", out_valid, 0);
            chk("rstmid_ready_after", in_ready, 1);
        end

        // Random masks and ready patterns against the bit-list model
        for (int r = 0; r < 40; r++) begin
            run_mask(8'($urandom), 2, nb, fi, la);
        end

        // N = 5 exhaustive
        for (int m = 0; m < 32; m++) begin
            mq.delete();
            for (int i = 0; i < 5; i++) if (m[i]) mq.push_back(i);
            @(negedge clk); v5 = 1'b1; m5 = 5'(m);
            @(posedge clk); #1 v5 = 1'b0;
            got = 0; lasts = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (ov5) begin
                    chk("n5_idx", idx5, (got < mq.size()) ? mq[got] : 99);
                    chk("n5_cnt", cnt5, mq.size());
                    if (ol5) begin
                        lasts++;
                        chk("n5_last_is_final", got, mq.size() - 1);
                    end
                    got++;
                end
            end
            chk("n5_beats", got, mq.size());
            chk("n5_lasts", lasts, (m != 0));
        end

        // N = 1 exhaustive
        for (int m = 0; m < 2; m++) begin
            @(negedge clk); v1 = 1'b1; m1 = 1'(m);
            @(posedge clk); #1 v1 = 1'b0;
            got = 0; lasts = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (ov1) begin
                    chk("n1_idx", idx1, 0);
                    chk("n1_cnt", cnt1, 1);
                    if (ol1) lasts++;
                    got++;
                end
            end
            chk("n1_beats", got, m);
            chk("n1_lasts", lasts, m);
            chk("n1_ready", r1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_mask_serializer.md
# rv_mask_serializer

Sequential consumer of a thread mask: accepts an N-bit mask over a valid/ready handshake and emits the index of each set bit, lowest first, one per output handshake, with the mask's total ones-count and the beat position. It sits between warp-level issue logic and per-lane units that must process active threads one at a time, such as scatter/gather memory or CSR access. It is the reader side of the mask whose population the popcount block computes.

## Interface
- N, 4, mask width (number of lanes); N >= 1
- IDXW, $clog2(N) (forced to 1 when N == 1), width of lane index
- M, $clog2(N+1), width of counts
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid_i  input  1  mask offered
- in_ready_o  output  1  block can accept a mask
- in_mask_i  input  N  lane mask
- out_valid_o  output  1  beat available
- out_ready_i  input  1  consumer takes beat
- out_idx_o  output  IDXW  index of the current lowest pending set bit
- out_last_o  output  1  current beat is the final one of the mask
- out_cnt_o  output  M  total ones in the captured mask, constant during the batch
- out_pos_o  output  M  0-based beat number within the batch

## Operation
- Two states:
  - IDLE: in_ready_o=1, out_valid_o=0.
  - EMIT: in_ready_o=0, except with the macro (see Configuration), out_valid_o=1.
- Accept occurs when in_valid_i && in_ready_o at a rising edge.
  - Nonzero mask: pending <= in_mask_i, cnt <= popcount(in_mask_i), pos <= 0, state -> EMIT.
  - Zero mask: accepted and discarded. State stays IDLE, no beats are produced, in_ready_o stays 1.
- EMIT outputs:
  - out_idx_o = priority encode of pending, lowest set bit.
  - out_last_o = (pending has exactly one bit set), equivalently pos == cnt-1.
- Output handshake (out_valid_o && out_ready_i):
  - Clear the pending bit at out_idx_o and increment pos.
  - If out_last_o, go to IDLE and clear pending.
- When out_ready_i=0, out_idx_o, out_last_o, out_cnt_o and out_pos_o hold stable.
- In IDLE, out_idx_o, out_cnt_o and out_pos_o are don't-care but must not be X. They are driven from registers reset to 0.
- Arithmetic:
  - cnt uses M bits. An all-ones mask gives cnt=N, which fits.
  - pos never exceeds cnt-1.
- N == 1: out_idx_o=0. A set mask gives one beat with last=1 and cnt=1.

## Timing
- Reset (reset_n low, asynchronous):
  - state=IDLE, pending=0, cnt=0, pos=0.
  - Outputs: in_ready_o=1, out_valid_o=0, out_idx_o=0, out_last_o=0, out_cnt_o=0, out_pos_o=0.
- Reset mid-batch aborts the batch. Remaining beats are dropped and nothing is emitted after release.
- Latency: a mask accepted at edge T gives out_valid_o=1 from just after T, so the first beat can handshake at edge T+1.
- Throughput: one beat per cycle while out_ready_i=1. A mask with k set bits occupies k cycles in EMIT.
- Without the macro there is one bubble cycle (IDLE) between batches.
- Output-side signals derive only from registers. There is no combinational path from in_* to out_*.

## Configuration
- Macro RV_MASK_SER_BYPASS_EN.
- Defined:
  - in_ready_o = (state==IDLE) || (out_valid_o && out_ready_i && out_last_o).
  - A mask accepted on the final-beat edge reloads pending, cnt and pos directly, staying in EMIT (or going to IDLE if the mask is zero). Batches run back to back with no bubble.
  - This creates a combinational path out_ready_i -> in_ready_o.
- Undefined: in_ready_o = (state==IDLE), fully registered, with one bubble between batches.

## Test plan
- N=8, mask 8'b1010_0110, out_ready_i=1 constant -> beats idx 1,2,5,7 on four consecutive cycles; cnt=4; pos=0..3; last only on idx 7; then IDLE with in_ready_o=1.
- N=8, mask 8'hFF, out_ready_i toggled 1,0,1,0,... -> idx 0..7 in order, held stable during stalls; cnt=8; last on idx 7.
- Zero mask accepted, then 8'h01 -> no beats for the zero mask; the next mask gives a single beat with idx 0, cnt 1, last 1.
- Back-to-back 8'h81 then 8'h02 with in_valid_i held high:
  - Without macro: beats idx 0, 7, then a one-cycle gap, then idx 1.
  - With RV_MASK_SER_BYPASS_EN: idx 0, 7, 1 on three consecutive cycles.
- reset_n asserted for one cycle after the second beat of 8'hF0 -> out_valid_o drops immediately; no idx 6 or 7 beats appear; all outputs at reset values; in_ready_o=1 after release.
- N=1 and N=5 builds, exhaustive masks -> beat count equals popcount for every mask; indices strictly ascending; exactly one last per nonzero mask.
